// File: rtl/hier_node_pkg.sv
// hier_node_pkg: shared FSM state and run-mode encodings for hier_node_ctrl
package hier_node_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_PAR = 2'd1,
        RUN_SEQ = 2'd2,
        FINISH  = 2'd3
    } state_t;
    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SEQ = 1'b1;
endpackage

// File: rtl/hier_tmo_cnt.sv
// hier_tmo_cnt: loadable down-counter that flags expiry while enabled and not being reloaded
module hier_tmo_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_expired = i_en && !i_load && (r_cnt == '0);
endmodule

// File: rtl/hier_node_ctrl.sv
// hier_node_ctrl: launches child channels in parallel or in sequence and collects errors/timeouts
module hier_node_ctrl
    import hier_node_pkg::*;
#(
    parameter int N_CHILD = 5,
    parameter int TMO_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [TMO_W-1:0]   tmo_i,
    output logic [N_CHILD-1:0] child_start_o,
    input  logic [N_CHILD-1:0] child_done_i,
    input  logic [N_CHILD-1:0] child_err_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [N_CHILD-1:0] err_mask_o,
    output logic               tmo_o
);
    localparam int IW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_CHILD - 1);
    localparam logic [N_CHILD-1:0] ALL = '1;
    localparam logic [N_CHILD-1:0] ONE = N_CHILD'(1);

    state_t             r_state;
    logic [N_CHILD-1:0] r_cstart;
    logic [N_CHILD-1:0] r_pending;
    logic [N_CHILD-1:0] r_err;
    logic [IW-1:0]      r_idx;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_tmo_flag;
    logic               w_run;
    logic               w_exp;
    logic               w_seq_done;
    logic [N_CHILD-1:0] w_sel;
    logic [N_CHILD-1:0] w_left;

    assign w_run      = (r_state == RUN_PAR) || (r_state == RUN_SEQ);
    assign w_sel      = ONE << r_idx;
    assign w_left     = r_pending & ~child_done_i;
    assign w_seq_done = |(child_done_i & w_sel);

    // the counter reloads on every launch pulse, so expiry is never judged against a stale count
    hier_tmo_cnt #(.W(TMO_W)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_load    (|r_cstart),
        .i_en      (w_run && (r_tmo != '0)),
        .i_val     (r_tmo),
        .o_expired (w_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cstart   <= '0;
            r_pending  <= '0;
            r_err      <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_tmo_flag <= 1'b0;
        end else begin
            r_cstart <= '0;
            case (r_state)
                IDLE: if (start_i) begin
                    r_state    <= (mode_i == MODE_SEQ) ? RUN_SEQ : RUN_PAR;
                    r_cstart   <= (mode_i == MODE_PAR) ? ALL : ONE;
                    r_pending  <= ALL;
                    r_idx      <= '0;
                    r_err      <= '0;
                    r_tmo_flag <= 1'b0;
                    r_tmo      <= tmo_i;
                end
                RUN_PAR: begin
                    // completions in the expiry cycle are removed from w_left, so they win
                    r_err     <= r_err | (child_done_i & r_pending & child_err_i) | (w_exp ? w_left : '0);
                    r_pending <= w_exp ? '0 : w_left;
                    if (w_left == '0) r_state <= FINISH;
                    else if (w_exp) begin
                        r_tmo_flag <= 1'b1;
                        r_state    <= FINISH;
                    end
                end
                RUN_SEQ: if (w_seq_done) begin
                    r_err <= r_err | (w_sel & child_err_i);
                    if (r_idx == LAST) r_state <= FINISH;
                    else begin
                        r_idx    <= r_idx + 1'b1;
                        r_cstart <= w_sel << 1;
                    end
                end else if (w_exp) begin
                    r_err      <= r_err | w_sel;
                    r_tmo_flag <= 1'b1;
                    r_state    <= FINISH;
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= '0;
                    r_idx     <= '0;
                end
            endcase
        end
    end

    assign child_start_o = r_cstart;
    assign busy_o        = (r_state != IDLE);
    assign done_o        = (r_state == FINISH);
    assign err_mask_o    = r_err;
    assign tmo_o         = r_tmo_flag;
endmodule

// File: tb/tb_hier_node_ctrl.sv
// tb_hier_node_ctrl: directed scoreboard bench for hier_node_ctrl run modes, timeouts and reset
module tb_hier_node_ctrl;
    import hier_node_pkg::*;
    localparam int N  = 5;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          mode_i;
    logic [TW-1:0] tmo_i;
    logic [N-1:0]  child_start_o;
    logic [N-1:0]  child_done_i;
    logic [N-1:0]  child_err_i;
    logic          busy_o;
    logic          done_o;
    logic [N-1:0]  err_mask_o;
    logic          tmo_o;

    typedef struct {
        logic [N-1:0] mask;
        logic         tmo;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] cs_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           l0;

    hier_node_ctrl #(.N_CHILD(N), .TMO_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .tmo_i         (tmo_i),
        .child_start_o (child_start_o),
        .child_done_i  (child_done_i),
        .child_err_i   (child_err_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_mask_o    (err_mask_o),
        .tmo_o         (tmo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // advance one cycle, then score launch pulses and run completions against the queues
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (child_start_o != '0) begin
            if (cs_q.size() == 0) chk("cs_unexpected", 32'(child_start_o), 32'd0);
            else chk("cs_order", 32'(child_start_o), 32'(cs_q.pop_front()));
        end
        if (done_o) begin
            if (sb.size() == 0) chk("done_unexpected", 32'(done_o), 32'd0);
            else begin
                e = sb.pop_front();
                chk("done_cyc", 32'(cyc), 32'(e.cyc));
                chk("err_mask", 32'(err_mask_o), 32'(e.mask));
                chk("tmo", 32'(tmo_o), 32'(e.tmo));
            end
        end
    endtask

    task automatic launch(input logic mode, input logic [TW-1:0] tmo);
        start_i = 1'b1;
        mode_i  = mode;
        tmo_i   = tmo;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy_o; i++) step();
        chk("idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [N-1:0] par_ofs [5];
        par_ofs = '{5'b00010, 5'b01000, 5'b00001, 5'b00100, 5'b10000};
        rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; tmo_i = '0;
        child_done_i = '0; child_err_i = '0;
        step(); step();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_cs", 32'(child_start_o), 32'd0);
        chk("rst_err", 32'(err_mask_o), 32'd0);
        chk("rst_tmo", 32'(tmo_o), 32'd0);
        rst = 1'b0;
        step();

        // parallel, dones at launch offsets 3,1,4,2,5
        cs_q.push_back(5'b11111);
        launch(MODE_PAR, 8'd20);
        l0 = cyc;
        sb.push_back('{5'b00000, 1'b0, l0 + 6});
        for (int c = 0; c < 5; c++) begin
            step();
            child_done_i = par_ofs[c];
        end
        step();
        child_done_i = '0;
        wait_done(5);
        wait_idle(5);

        // sequential, child 2 reports an error
        for (int k = 0; k < N; k++) cs_q.push_back(5'(1 << k));
        launch(MODE_SEQ, 8'd20);
        l0 = cyc;
        sb.push_back('{5'b00100, 1'b0, l0 + 10});
        for (int k = 0; k < N; k++) begin
            step();
            child_done_i = 5'(1 << k);
            child_err_i  = (k == 2) ? 5'(1 << k) : '0;
            step();
            child_done_i = '0;
            child_err_i  = '0;
        end
        wait_done(5);
        wait_idle(5);
        chk("seq_cs_left", 32'(cs_q.size()), 32'd0);

        // parallel timeout, child 3 never completes
        cs_q.push_back(5'b11111);
        launch(MODE_PAR, 8'd4);
        l0 = cyc;
        sb.push_back('{5'b01000, 1'b1, l0 + 6});
        step();
        child_done_i = 5'b10111;
        step();
        child_done_i = '0;
        wait_done(10);
        wait_idle(5);
        step(); step(); step();
        chk("hold_err", 32'(err_mask_o), 32'h08);
        chk("hold_tmo", 32'(tmo_o), 32'd1);

        // sequential, child 1 completes in its expiry cycle
        for (int k = 0; k < N; k++) cs_q.push_back(5'(1 << k));
        launch(MODE_SEQ, 8'd3);
        l0 = cyc;
        chk("clr_err", 32'(err_mask_o), 32'd0);
        chk("clr_tmo", 32'(tmo_o), 32'd0);
        sb.push_back('{5'b00000, 1'b0, l0 + 9});
        child_done_i = 5'b00001;
        step();
        child_done_i = '0;
        repeat (4) step();
        child_done_i = 5'b00010;
        step();
        for (int k = 2; k < N; k++) begin
            child_done_i = 5'(1 << k);
            step();
        end
        child_done_i = '0;
        wait_done(5);
        wait_idle(5);
        chk("race_cs_left", 32'(cs_q.size()), 32'd0);

        // reset while child 3 of a sequential run is outstanding
        for (int k = 0; k < 4; k++) cs_q.push_back(5'(1 << k));
        launch(MODE_SEQ, 8'd0);
        child_done_i = 5'b00001;
        step();
        child_done_i = 5'b00010;
        child_err_i  = 5'b00010;
        step();
        child_done_i = 5'b00100;
        child_err_i  = '0;
        step();
        child_done_i = '0;
        chk("mid_err", 32'(err_mask_o), 32'h02);
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_cs", 32'(child_start_o), 32'd0);
        chk("abort_err", 32'(err_mask_o), 32'd0);
        chk("abort_tmo", 32'(tmo_o), 32'd0);
        rst = 1'b0;
        child_done_i = 5'b01000;
        step();
        child_done_i = '0;
        step();
        chk("stray_busy", 32'(busy_o), 32'd0);
        chk("stray_err", 32'(err_mask_o), 32'd0);
        chk("abort_cs_left", 32'(cs_q.size()), 32'd0);

        // start held high, timeout disabled, long child delay
        cs_q.push_back(5'b11111);
        cs_q.push_back(5'b11111);
        start_i = 1'b1; mode_i = MODE_PAR; tmo_i = '0;
        step();
        l0 = cyc;
        sb.push_back('{5'b00000, 1'b0, l0 + 31});
        repeat (30) step();
        child_done_i = '1;
        step();
        child_done_i = '0;
        step();
        chk("held_idle", 32'(busy_o), 32'd0);
        step();
        chk("held_rerun", 32'(busy_o), 32'd1);
        start_i = 1'b0;
        sb.push_back('{5'b00000, 1'b0, l0 + 34});
        child_done_i = '1;
        step();
        child_done_i = '0;
        wait_done(5);
        wait_idle(5);
        chk("held_cs_left", 32'(cs_q.size()), 32'd0);
        chk("held_tmo", 32'(tmo_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hier_node_ctrl.md
HIER_NODE_CTRL -- requirements
Module: hier_node_ctrl

Interface
REQ-001 Parameter N_CHILD, default 5, is the number of child channels, legal range 1..32.
REQ-002 Parameter TMO_W, default 8, is the per-child timeout counter width.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, is a synchronous, active-high reset.
REQ-005 Port start_i, input, 1, requests a run; sampled only in IDLE.
REQ-006 Port mode_i, input, 1, selects the run mode: 0 parallel, 1 sequential; latched with start_i.
REQ-007 Port tmo_i, input, TMO_W, is the timeout cycle count, latched with start_i; 0 disables the timeout.
REQ-008 Port child_start_o, output, N_CHILD, carries the one-cycle start pulse per child.
REQ-009 Port child_done_i, input, N_CHILD, carries the one-cycle completion pulse per child.
REQ-010 Port child_err_i, input, N_CHILD, carries the error flag per child, valid only with child_done_i.
REQ-011 Port busy_o, output, 1, is high whenever the state is not IDLE.
REQ-012 Port done_o, output, 1, is a one-cycle run-complete pulse.
REQ-013 Port err_mask_o, output, N_CHILD, marks children that errored or timed out in the last run.
REQ-014 Port tmo_o, output, 1, is high if the last run ended by timeout.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN_PAR, RUN_SEQ and FINISH.
- IDLE -> RUN_PAR on start_i with mode_i=0.
- IDLE -> RUN_SEQ on start_i with mode_i=1.
REQ-016 Launch latency SHALL be one cycle: start_i at cycle t -> child_start_o asserted at t+1.
- Parallel: all ones.
- Sequential: bit 0 only.
REQ-017 RUN_PAR behaviour:
- pending mask loads all ones at launch.
- child_done_i[k] clears pending[k]; err_mask[k] |= child_err_i[k].
- pending==0 -> FINISH.
REQ-018 RUN_SEQ behaviour:
- Index idx starts at 0.
- child_done_i[idx] records its error bit; idx increments, and child_start_o[idx+1] pulses the next cycle.
- Done for idx==N_CHILD-1 -> FINISH.
REQ-019 child_done_i bits that are not pending (parallel) or not equal to idx (sequential) SHALL be ignored.
REQ-020 Simultaneous done pulses in RUN_PAR SHALL all be accepted in the same cycle.
REQ-021 The timeout counter SHALL:
- load tmo_i at each launch (parallel launch, or each sequential child launch);
- decrement every cycle in which a completion is outstanding.
REQ-022 A counter reaching 0 while work is pending (and tmo_i != 0) SHALL:
- OR the pending children (parallel) or child idx (sequential) into err_mask;
- set tmo_o;
- move to FINISH, so later children in a sequential run are not launched.
REQ-023 A completion arriving in the same cycle as expiry SHALL win; no timeout is recorded for that child.
REQ-024 FINISH SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-025 err_mask_o and tmo_o SHALL hold until the next accepted start_i, which clears both.
REQ-026 start_i outside IDLE SHALL be ignored, not queued.
REQ-027 The minimum run is: start at t, launch at t+1, done at t+1, FINISH at t+2, done_o at t+2, IDLE at t+3.

Reset
REQ-028 On rst the block SHALL force:
- state IDLE;
- child_start_o, pending, idx, counter, err_mask_o, tmo_o, done_o and busy_o all to 0.
REQ-029 rst mid-run SHALL abort the run without issuing done_o; late child_done_i pulses after reset SHALL be ignored.

Structure
REQ-030 The state enum and the mode encoding constants (MODE_PAR=0, MODE_SEQ=1) SHALL live in the shared package hier_node_pkg.
REQ-031 The timeout counter SHALL be a sub-module hier_tmo_cnt with load, enable and expired outputs; everything else is flat.

Verification
REQ-032 Parallel run, N_CHILD=5, tmo_i=20, dones at offsets 3,1,4,2,5 -> done_o 1 cycle after the last done, err_mask_o=0, tmo_o=0.
REQ-033 Sequential run, child 2 returns err=1 -> child_start_o pulses 00001, 00010, 00100, 01000, 10000 in order; err_mask_o=00100.
REQ-034 Parallel run, tmo_i=4, child 3 never completes -> tmo_o=1, err_mask_o=01000, done_o 6 cycles after launch.
REQ-035 Sequential run, child 1 done lands in the same cycle as expiry, tmo_i=3 -> no timeout; run continues to child 2.
REQ-036 rst asserted during RUN_SEQ at idx=3 -> next cycle: outputs zero, no done_o; a stray child_done_i[3] afterwards has no effect.
REQ-037 start_i held high through a run, tmo_i=0 -> exactly one run, no timeout regardless of delay; a second run starts the cycle after return to IDLE.
